// File: rtl/uart_tx_piso.sv
// UART transmitter: parallel word in through a load/ready handshake, serial frame out on txout.
// Frame is start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits.
module uart_tx_piso #(
    parameter int DATA_BITS    = 5,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 load,
    output logic                 ready,
    output logic                 txout,
    output logic                 busy,
    output logic                 done
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [2:0]           bit_q, bit_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic                 txout_q, txout_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 baud_wrap;

    assign baud_wrap = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        bit_d   = bit_q;
        baud_d  = '0;
        txout_d = txout_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                txout_d = 1'b1;
                if (load && ready_q) begin
                    shreg_d = din;
                    par_d   = (^din) ^ 1'(PARITY_ODD);
                    state_d = START;
                    txout_d = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    txout_d = shreg_q[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    // txout is registered, so it must be loaded with the bit that follows the shift
                    shreg_d = shreg_q >> 1;
                    txout_d = shreg_q[1];
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            txout_d = par_q;
                        end else begin
                            state_d = STOP;
                            txout_d = 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    state_d = STOP;
                    txout_d = 1'b1;
                end
            end
            STOP: begin
                txout_d = 1'b1;
                done_d  = (bit_q == 3'(STOP_BITS - 1)) && (baud_q == BW'(CLKS_PER_BIT - 2));
                if (baud_wrap) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            baud_q  <= '0;
            txout_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            txout_q <= txout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign txout = txout_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_uart_tx_piso.sv
// Bench for uart_tx_piso: three instances (even parity, odd parity, no parity) at 4 clks/bit,
// table-driven frames, hand-written corner sequences and random frames against a frame model.
module tb_uart_tx_piso;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst  [3];
    logic       load [3];
    logic [4:0] din  [3];
    logic       ready [3];
    logic       txo   [3];
    logic       busy  [3];
    logic       done  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_piso #(.DATA_BITS(5), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst[0]), .din(din[0]), .load(load[0]),
        .ready(ready[0]), .txout(txo[0]), .busy(busy[0]), .done(done[0]));
    uart_tx_piso #(.DATA_BITS(5), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst[1]), .din(din[1]), .load(load[1]),
        .ready(ready[1]), .txout(txo[1]), .busy(busy[1]), .done(done[1]));
    uart_tx_piso #(.DATA_BITS(5), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
        .clk(clk), .rst(rst[2]), .din(din[2]), .load(load[2]),
        .ready(ready[2]), .txout(txo[2]), .busy(busy[2]), .done(done[2]));

    typedef struct {
        int       idx;
        logic [4:0] d;
        int       par;   // expected parity bit, -1 when the frame has none
        int       len;   // expected frame length in clk cycles
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int idx, input string nm);
        chk({nm, " txout"}, 32'(txo[idx]), 32'd1);
        chk({nm, " ready"}, 32'(ready[idx]), 32'd1);
        chk({nm, " busy"}, 32'(busy[idx]), 32'd0);
        chk({nm, " done"}, 32'(done[idx]), 32'd0);
    endtask

    // After this returns the bench is in cycle 1 of the accepted frame.
    task automatic capture(input int idx, input logic [4:0] d, input bit hold);
        load[idx] = 1'b1;
        din[idx]  = d;
        step();
        if (!hold) load[idx] = 1'b0;
    endtask

    // Checks cycles 1..len of a frame and the idle cycle after it; inject>0 pulses a stray load.
    task automatic check_frame(input int idx, input logic [4:0] d, input int par, input int len,
                               input int inject, input string nm);
        int bits[$];
        bits.push_back(0);
        for (int i = 0; i < 5; i++) bits.push_back(int'(d[i]));
        if (par >= 0) bits.push_back(par);
        while (bits.size() < len / C) bits.push_back(1);
        for (int cyc = 1; cyc <= len; cyc++) begin
            chk($sformatf("%s txout c%0d", nm, cyc), 32'(txo[idx]), 32'(bits[(cyc - 1) / C]));
            chk($sformatf("%s busy c%0d", nm, cyc), 32'(busy[idx]), 32'd1);
            chk($sformatf("%s ready c%0d", nm, cyc), 32'(ready[idx]), 32'd0);
            chk($sformatf("%s done c%0d", nm, cyc), 32'(done[idx]), 32'(cyc == len));
            if (inject > 0 && cyc == inject) begin
                load[idx] = 1'b1;
                din[idx]  = 5'b01001;
            end
            if (inject > 0 && cyc == inject + 1) load[idx] = 1'b0;
            step();
        end
        chk_idle(idx, {nm, " after"});
    endtask

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; load[i] = 1'b1; din[i] = 5'b11111;
        end

        // Reset held two cycles with load asserted: nothing may start.
        step();
        for (int i = 0; i < 3; i++) chk_idle(i, "rst1");
        step();
        for (int i = 0; i < 3; i++) chk_idle(i, "rst2");
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; load[i] = 1'b0;
        end
        step();
        for (int i = 0; i < 3; i++) chk_idle(i, "postrst");

        vecs.push_back('{0, 5'b10110, 1, 32});
        vecs.push_back('{1, 5'b00000, 1, 32});
        vecs.push_back('{2, 5'b00000, -1, 28});
        vecs.push_back('{0, 5'b00000, 0, 32});
        vecs.push_back('{0, 5'b11111, 1, 32});
        vecs.push_back('{1, 5'b11111, 0, 32});
        vecs.push_back('{1, 5'b10110, 0, 32});
        vecs.push_back('{2, 5'b10110, -1, 28});
        foreach (vecs[k]) begin
            capture(vecs[k].idx, vecs[k].d, 1'b0);
            check_frame(vecs[k].idx, vecs[k].d, vecs[k].par, vecs[k].len, 0, $sformatf("vec%0d", k));
            step();
        end

        // Stray load at cycle 10 is ignored and not queued.
        capture(0, 5'b10110, 1'b0);
        check_frame(0, 5'b10110, 1, 32, 10, "ignore");
        for (int i = 0; i < 2 * C; i++) begin
            step();
            chk("ignore noframe txout", 32'(txo[0]), 32'd1);
            chk("ignore noframe ready", 32'(ready[0]), 32'd1);
        end

        // Back-to-back with load held: exactly one idle-high cycle between frames.
        capture(0, 5'b00001, 1'b1);
        din[0] = 5'b11110;
        check_frame(0, 5'b00001, 1, 32, 0, "b2b1");
        step();
        load[0] = 1'b0;
        check_frame(0, 5'b11110, 0, 32, 0, "b2b2");
        step();

        // Reset during d2 aborts the frame; a fresh frame is then intact.
        capture(0, 5'b10110, 1'b0);
        for (int i = 1; i < 14; i++) step();
        chk("midrst in d2", 32'(txo[0]), 32'd1);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk_idle(0, "midrst");
        capture(0, 5'b01101, 1'b0);
        check_frame(0, 5'b01101, 1, 32, 0, "postabort");

        // Random frames against the model: parity from a popcount, length from the frame format.
        for (int r = 0; r < 24; r++) begin
            int idx;
            int ones;
            int par;
            logic [4:0] d;
            idx  = int'($urandom_range(2, 0));
            d    = 5'($urandom);
            ones = 0;
            for (int b = 0; b < 5; b++) ones += int'(d[b]);
            par  = (idx == 0) ? (ones % 2) : (idx == 1) ? (1 - ones % 2) : -1;
            for (int g = int'($urandom_range(3, 0)); g > 0; g--) step();
            capture(idx, d, 1'b0);
            check_frame(idx, d, par, (idx == 2) ? 7 * C : 8 * C, 0, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
